// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand forwarding stage.
// Source tag 0 always names the register file; tags 1..NSRC name forwarding sources.
package fwd_pkg;

  localparam int SEL_RF   = 0;
  localparam int REG_ZERO = 0;

  // Width of a source tag able to encode the register file plus nsrc forwarding sources.
  function automatic int sel_width(input int nsrc);
    return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: finds the youngest in-flight writer of rs_addr.
// Purely combinational; no state and no handshake.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NSRC = 3,
  parameter int SW   = sel_width(NSRC)
) (
  input  logic [AW-1:0]      rs_addr,
  input  logic [NSRC-1:0]    fwd_we,
  input  logic [NSRC-1:0]    fwd_pend,
  input  logic [NSRC*AW-1:0] fwd_addr,
  output logic               hit,
  output logic [SW-1:0]      winner,
  output logic               winner_pend
);

  // Scan oldest to youngest so the lowest matching index overwrites, shadowing older pend state.
  always_comb begin
    hit         = 1'b0;
    winner      = '0;
    winner_pend = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr[i*AW +: AW] == rs_addr) && (rs_addr != AW'(REG_ZERO))) begin
        hit         = 1'b1;
        winner      = SW'(i);
        winner_pend = fwd_pend[i];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// NSRC-way operand forwarder with load-use hazard detection, registered behind valid/ready.
// 1-cycle latency; holds output and drops in_ready under backpressure or hazard.
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 3,
  localparam int SW   = sel_width(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         rs_addr,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic [NSRC-1:0]       fwd_we,
  input  logic [NSRC-1:0]       fwd_pend,
  input  logic [NSRC*AW-1:0]    fwd_addr,
  input  logic [NSRC*WIDTH-1:0] fwd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_sel,
  output logic                  hazard,
  output logic [15:0]           stall_cnt
);

  logic             hit;
  logic [SW-1:0]    winner;
  logic             winner_pend;
  logic [WIDTH-1:0] fwd_sel;
  logic [WIDTH-1:0] nxt_data;
  logic [SW-1:0]    nxt_sel;
  logic             capture;

  fwd_match #(
    .AW   (AW),
    .NSRC (NSRC),
    .SW   (SW)
  ) u_match (
    .rs_addr     (rs_addr),
    .fwd_we      (fwd_we),
    .fwd_pend    (fwd_pend),
    .fwd_addr    (fwd_addr),
    .hit         (hit),
    .winner      (winner),
    .winner_pend (winner_pend)
  );

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (winner == SW'(i)) fwd_sel = fwd_data[i*WIDTH +: WIDTH];
    end

    // x0 reads as zero regardless of what the register file or any source claims.
    if (rs_addr == AW'(REG_ZERO)) begin
      nxt_data = '0;
      nxt_sel  = SW'(SEL_RF);
    end else if (hit && !winner_pend) begin
      nxt_data = fwd_sel;
      nxt_sel  = winner + SW'(1);
    end else begin
      nxt_data = rf_data;
      nxt_sel  = SW'(SEL_RF);
    end
  end

  assign hazard   = in_valid && hit && winner_pend;
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= nxt_data;
      out_sel   <= nxt_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage with hand-computed expectations.
module tb_fwd_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [31:0] rf_data;
  logic [2:0]  fwd_we;
  logic [2:0]  fwd_pend;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        hazard;
  logic [15:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fwd_operand_stage #(.WIDTH(32), .AW(5), .NSRC(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_addr   (rs_addr),
    .rf_data   (rf_data),
    .fwd_we    (fwd_we),
    .fwd_pend  (fwd_pend),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .hazard    (hazard),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rs_addr  = '0;
    rf_data  = '0;
    fwd_we   = '0;
    fwd_pend = '0;
    fwd_addr = '0;
    fwd_data = '0;
    flush    = 1'b0;
    out_ready = 1'b1;

    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    // Plain register-file read.
    rs_addr = 5'd5; rf_data = 32'hAAAA0000; in_valid = 1'b1;
    #1;
    chk("rf_in_ready", 32'(in_ready), 32'd1);
    chk("rf_hazard",   32'(hazard),   32'd0);
    tick();
    chk("rf_out_valid", 32'(out_valid), 32'd1);
    chk("rf_out_data",  out_data,       32'hAAAA0000);
    chk("rf_out_sel",   32'(out_sel),   32'd0);

    // Sources 1 and 2 both match; source 0 matches address but does not write.
    fwd_addr = {5'd5, 5'd5, 5'd5};
    fwd_we   = 3'b110;
    fwd_data = {32'h22, 32'h11, 32'h33};
    tick();
    chk("prio_out_data", out_data,     32'h11);
    chk("prio_out_sel",  32'(out_sel), 32'd2);

    // x0 is forced to zero even when every source claims to write it.
    rs_addr = 5'd0; fwd_addr = '0; fwd_we = 3'b111;
    fwd_data = {32'hFFFF, 32'hFFFF, 32'hFFFF}; rf_data = 32'h1234;
    tick();
    chk("x0_out_data", out_data,     32'd0);
    chk("x0_out_sel",  32'(out_sel), 32'd0);

    // Load-use: source 0 pending for three cycles.
    rs_addr = 5'd7; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_we = 3'b001;
    fwd_pend = 3'b001; fwd_data = {32'h0, 32'h0, 32'h77};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lu_hazard",   32'(hazard),   32'd1);
      chk("lu_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("lu_drained",   32'(out_valid), 32'd0);
    fwd_pend = 3'b000;
    #1;
    chk("lu_clear_hazard", 32'(hazard), 32'd0);
    tick();
    chk("lu_out_data",  out_data,       32'h77);
    chk("lu_out_sel",   32'(out_sel),   32'd1);
    chk("lu_stall_hold", 32'(stall_cnt), 32'd3);

    // Older pending producer is shadowed by a ready younger one.
    fwd_addr = {5'd0, 5'd7, 5'd7}; fwd_we = 3'b011; fwd_pend = 3'b010;
    fwd_data = {32'h0, 32'h99, 32'h55};
    #1;
    chk("shadow_hazard", 32'(hazard), 32'd0);
    tick();
    chk("shadow_out_data", out_data,     32'h55);
    chk("shadow_out_sel",  32'(out_sel), 32'd1);

    // Backpressure: output holds, no new request accepted.
    fwd_we = 3'b000; fwd_pend = 3'b000; rs_addr = 5'd9; rf_data = 32'hBEEF;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  out_data,       32'h55);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("b2b0_out_data", out_data, 32'hBEEF);
    rf_data = 32'hCAFE;
    tick();
    chk("b2b1_out_data",  out_data,       32'hCAFE);
    chk("b2b1_out_valid", 32'(out_valid), 32'd1);

    // Flush beats a simultaneous capture; the data register holds.
    rf_data = 32'hD00D; flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data",  out_data,       32'hCAFE);
    flush = 1'b0; in_valid = 1'b0;

    // Saturation: 70000 further hazard cycles on top of the existing count of 3.
    in_valid = 1'b1; rs_addr = 5'd7; fwd_addr = {5'd0, 5'd0, 5'd7};
    fwd_we = 3'b001; fwd_pend = 3'b001;
    repeat (70000) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);

    // Reset mid-transfer discards the registered operand.
    fwd_pend = 3'b000; fwd_data = {32'h0, 32'h0, 32'h42};
    tick();
    chk("mid_out_data", out_data, 32'h42);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
